// File: rtl/mesh_pe_nic_arbiter_pkg.sv
// mesh_pe_nic_arbiter_pkg: shared defaults and injection buffer state for the PE network interface
package mesh_pe_nic_arbiter_pkg;
  localparam int NREQ_DEF = 4;
  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF = 16;
  typedef enum logic {EMPTY, FULL} inj_state_t;
endpackage

// File: rtl/mesh_pe_nic_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant starting at ptr, wrapping, with next pointer past the winner
module rr_arbiter #(
  parameter int N = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] nxt_ptr
);
  logic          found;
  logic [PW-1:0] idx;
  always_comb begin
    gnt = '0;
    nxt_ptr = ptr;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        nxt_ptr = PW'((int'(idx) + 1) % N);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mesh_pe_nic_arbiter.sv
// mesh_pe_nic_arbiter: RR injection of local requesters into a router PE port plus one-entry ejection buffer
module mesh_pe_nic_arbiter
  import mesh_pe_nic_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic                   pesi,
  input  logic                   pero,
  output logic [DATA_W-1:0]      pedi,
  input  logic                   peso,
  output logic                   peri,
  input  logic [DATA_W-1:0]      pedo,
  output logic                   ej_valid,
  input  logic                   ej_ready,
  output logic [DATA_W-1:0]      ej_data,
  output logic [CNT_W-1:0]       inj_cnt,
  output logic [CNT_W-1:0]       ej_cnt
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  inj_state_t        state, state_nxt;
  logic [DATA_W-1:0] pkt_q, sel_data;
  logic [PW-1:0]     ptr, ptr_nxt;
  logic              accept, can_load, any_gnt, ej_fill, ej_drain;
  assign accept = (state == FULL) && pero;
  assign can_load = (state == EMPTY) || accept;
  assign any_gnt = |gnt;
  assign pesi = (state == FULL);
  assign pedi = pkt_q;
  assign peri = !ej_valid || ej_ready;
  assign ej_fill = peso && peri;
  assign ej_drain = ej_valid && ej_ready;
  // Gating with rst_n keeps gnt low for the whole reset, not just after the first edge
  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .en      (can_load && rst_n),
    .gnt     (gnt),
    .nxt_ptr (ptr_nxt)
  );
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) sel_data = req_data[i*DATA_W +: DATA_W];
  end
  always_comb state_nxt = any_gnt ? FULL : accept ? EMPTY : state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      pkt_q <= '0;
      ptr <= '0;
      inj_cnt <= '0;
      ej_valid <= 1'b0;
      ej_data <= '0;
      ej_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (any_gnt) begin
        pkt_q <= sel_data;
        ptr <= ptr_nxt;
      end
      if (accept) inj_cnt <= inj_cnt + 1'b1;
      if (ej_fill) ej_data <= pedo;
      ej_valid <= ej_fill ? 1'b1 : ej_drain ? 1'b0 : ej_valid;
      if (ej_drain) ej_cnt <= ej_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mesh_pe_nic_arbiter.sv
// tb_mesh_pe_nic_arbiter: directed and random stimulus checked against a cycle model plus literal expectations
module tb_mesh_pe_nic_arbiter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = '0;
  logic [255:0] req_data = '0;
  logic [3:0]   gnt;
  logic         pesi, pero = 1'b0;
  logic [63:0]  pedi;
  logic         peso = 1'b0, peri;
  logic [63:0]  pedo = '0;
  logic         ej_valid, ej_ready = 1'b0;
  logic [63:0]  ej_data;
  logic [15:0]  inj_cnt, ej_cnt;
  int passed = 0, total = 0;

  mesh_pe_nic_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .pesi(pesi), .pero(pero), .pedi(pedi), .peso(peso), .peri(peri), .pedo(pedo),
    .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_data(ej_data),
    .inj_cnt(inj_cnt), .ej_cnt(ej_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: a one-slot injection queue, a rotating priority index and a one-slot ejection queue
  bit m_full, m_ejv, n_full, n_ejv;
  logic [63:0] m_data, m_ejd, n_data, n_ejd;
  int m_ptr, m_inj, m_ejc, n_ptr, n_inj, n_ejc;

  function automatic int winner(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++)
      if (((r >> ((p + k) % 4)) & 4'd1) != 0) return (p + k) % 4;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full = 0; m_data = '0; m_ptr = 0; m_inj = 0; m_ejv = 0; m_ejd = '0; m_ejc = 0;
    end else begin
      m_full = n_full; m_data = n_data; m_ptr = n_ptr; m_inj = n_inj;
      m_ejv = n_ejv; m_ejd = n_ejd; m_ejc = n_ejc;
    end
  end

  always @(negedge clk) begin
    int w;
    bit rdy;
    w = (rst_n && (!m_full || pero)) ? winner(req, m_ptr) : -1;
    rdy = !m_ejv || ej_ready;
    chk("gnt", gnt, (w >= 0) ? 64'(4'b0001 << w) : 64'd0);
    chk("pesi", pesi, m_full);
    chk("pedi", pedi, m_data);
    chk("peri", peri, rdy);
    chk("ej_valid", ej_valid, m_ejv);
    chk("ej_data", ej_data, m_ejd);
    chk("inj_cnt", inj_cnt, 64'(m_inj % 65536));
    chk("ej_cnt", ej_cnt, 64'(m_ejc % 65536));
    n_inj = m_inj + ((m_full && pero) ? 1 : 0);
    n_full = (w >= 0) ? 1 : (m_full && !pero);
    n_data = (w >= 0) ? req_data[w*64 +: 64] : m_data;
    n_ptr = (w >= 0) ? (w + 1) % 4 : m_ptr;
    n_ejc = m_ejc + ((m_ejv && ej_ready) ? 1 : 0);
    n_ejv = (peso && rdy) ? 1 : (m_ejv && ej_ready) ? 0 : m_ejv;
    n_ejd = (peso && rdy) ? pedo : m_ejd;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    step();
    rst_n = 1'b0;
    req = '0; pero = 1'b0; peso = 1'b0; ej_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    bit hit;
    step(); step();
    rst_n = 1'b1;
    req = 4'b1111;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("t1_gnt", gnt, 0);
    chk("t1_pesi", pesi, 0);
    chk("t1_peri", peri, 1);
    chk("t1_inj_cnt", inj_cnt, 0);
    chk("t1_ej_cnt", ej_cnt, 0);
    step();
    req = '0;
    rst_n = 1'b1;
    step();
    req = 4'b0100; req_data[128 +: 64] = 64'hA5; pero = 1'b1;
    #1 chk("t2_gnt", gnt, 4'b0100);
    step();
    req = '0;
    #1 chk("t2_pesi", pesi, 1);
    chk("t2_pedi", pedi, 64'hA5);
    step();
    #1 chk("t2_inj_cnt", inj_cnt, 1);
    pulse_reset();
    for (int i = 0; i < 4; i++) req_data[i*64 +: 64] = 64'h100 + 64'(i);
    req = 4'b1111; pero = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t3_gnt", gnt, 64'(4'b0001 << (i % 4)));
      if (i > 0) chk("t3_pesi", pesi, 1);
      step();
    end
    chk("t3_inj_cnt", inj_cnt, 4);
    pero = 1'b0; req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_gnt", gnt, 0);
      chk("t4_pedi", pedi, 64'h100);
      step();
    end
    pero = 1'b1;
    #1 chk("t4_gnt_after", gnt, 4'b0010);
    step();
    chk("t4_inj_cnt", inj_cnt, 5);
    chk("t4_pedi_next", pedi, 64'h101);
    req = '0;
    peso = 1'b1; pedo = 64'h1234; ej_ready = 1'b0;
    step();
    chk("t5_ej_valid", ej_valid, 1);
    chk("t5_peri", peri, 0);
    chk("t5_ej_data", ej_data, 64'h1234);
    pedo = 64'h9999;
    step();
    chk("t5_ignored", ej_data, 64'h1234);
    ej_ready = 1'b1; pedo = 64'h5678;
    #1 chk("t5_peri_pass", peri, 1);
    step();
    chk("t5_ej_data2", ej_data, 64'h5678);
    chk("t5_ej_valid2", ej_valid, 1);
    chk("t5_ej_cnt", ej_cnt, 1);
    peso = 1'b0;
    step();
    chk("t5_drained", ej_valid, 0);
    chk("t5_ej_cnt2", ej_cnt, 2);
    for (int i = 0; i < 300; i++) begin
      req = 4'($urandom);
      req_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pero = 1'($urandom); peso = 1'($urandom); ej_ready = 1'($urandom);
      pedo = {$urandom, $urandom};
      step();
    end
    peso = 1'b0; ej_ready = 1'b0;
    req = 4'b1111; pero = 1'b1;
    hit = 0;
    for (int i = 0; i < 70000 && !hit; i++) begin
      if (inj_cnt == 16'hFFFF) hit = 1;
      else step();
    end
    chk("t6_reach_ffff", inj_cnt, 16'hFFFF);
    step();
    chk("t6_wrap", inj_cnt, 0);
    req = '0; pero = 1'b0;
    step(); step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
